// File: rtl/prng_burst.sv
// Burst-mode random word generator with run-time selectable LCG or Galois LFSR.
// Words are streamed over a valid/ready interface; prng_r_dat is always the state register.
module prng_burst #(
    parameter int unsigned PRNG_DAT_W = 25,
    parameter int unsigned LCG_A      = 1664525,
    parameter int unsigned LCG_C      = 12345,
    parameter logic [PRNG_DAT_W-1:0] LFSR_TAPS = PRNG_DAT_W'('h1200000),
    parameter int unsigned BURST_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prng_t_sel,
    input  logic [1:0]            prng_typ_sel,
    input  logic [PRNG_DAT_W-1:0] prng_t_dat,
    input  logic [BURST_W-1:0]    prng_burst_len,
    output logic [PRNG_DAT_W-1:0] prng_r_dat,
    output logic                  prng_r_vld,
    input  logic                  prng_r_rdy,
    output logic                  prng_busy,
    output logic                  prng_err
);

    // state | meaning
    // IDLE  | no burst pending; seed, mode and start commands are accepted
    // RUN   | burst in flight; prng_r_dat is an unconsumed word, cnt = words left
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    localparam logic [1:0] CMD_HALT  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_SEED  = 2'd2;
    localparam logic [1:0] CMD_MODE  = 2'd3;

    localparam logic [PRNG_DAT_W-1:0] LCG_A_W = PRNG_DAT_W'(LCG_A);
    localparam logic [PRNG_DAT_W-1:0] LCG_C_W = PRNG_DAT_W'(LCG_C);
    localparam logic [PRNG_DAT_W-1:0] DAT_ZERO = '0;
    localparam logic [PRNG_DAT_W-1:0] DAT_ONE  = PRNG_DAT_W'(1);
    localparam logic [BURST_W-1:0]    CNT_ZERO = '0;
    localparam logic [BURST_W-1:0]    CNT_TC   = BURST_W'(1);

    localparam logic MODE_LCG  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    fsm_t                  fsm_q,   fsm_d;
    logic [PRNG_DAT_W-1:0] state_q, state_d;
    logic                  mode_q,  mode_d;
    logic [BURST_W-1:0]    cnt_q,   cnt_d;
    logic                  err_q,   err_d;

    logic [PRNG_DAT_W-1:0] state_nxt;
    logic                  cmd_halt;
    logic                  cmd_start;
    logic                  cmd_seed;
    logic                  cmd_mode;
    logic                  handshake;
    logic                  cnt_last;

    function automatic logic [PRNG_DAT_W-1:0] lcg_next(input logic [PRNG_DAT_W-1:0] s);
        return s * LCG_A_W + LCG_C_W;
    endfunction

    function automatic logic [PRNG_DAT_W-1:0] lfsr_next(input logic [PRNG_DAT_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    assign state_nxt = (mode_q == MODE_LFSR) ? lfsr_next(state_q) : lcg_next(state_q);

    assign cmd_halt  = prng_t_sel && (prng_typ_sel == CMD_HALT);
    assign cmd_start = prng_t_sel && (prng_typ_sel == CMD_START);
    assign cmd_seed  = prng_t_sel && (prng_typ_sel == CMD_SEED);
    assign cmd_mode  = prng_t_sel && (prng_typ_sel == CMD_MODE);

    assign handshake = (fsm_q == ST_RUN) && prng_r_rdy;
    assign cnt_last  = (cnt_q == CNT_TC);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (fsm_q)
            ST_IDLE: begin
                if (cmd_start && (prng_burst_len != CNT_ZERO)) begin
                    state_d = state_nxt;
                    cnt_d   = prng_burst_len;
                    fsm_d   = ST_RUN;
                end else if (cmd_seed) begin
                    // An all-zero seed would lock the LFSR, so it is refused.
                    if ((mode_q == MODE_LFSR) && (prng_t_dat == DAT_ZERO)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = prng_t_dat;
                        err_d   = 1'b0;
                    end
                end else if (cmd_mode) begin
                    mode_d = prng_t_dat[0];
                    if ((prng_t_dat[0] == MODE_LFSR) && (state_q == DAT_ZERO)) begin
                        state_d = DAT_ONE;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (cmd_halt) begin
                    // Abort wins over a same-edge handshake; state is left as the last word.
                    fsm_d = ST_IDLE;
                    cnt_d = CNT_ZERO;
                end else begin
                    if (cmd_start || cmd_seed || cmd_mode) begin
                        err_d = 1'b1;
                    end
                    if (handshake) begin
                        if (cnt_last) begin
                            fsm_d = ST_IDLE;
                            cnt_d = CNT_ZERO;
                        end else begin
                            state_d = state_nxt;
                            cnt_d   = cnt_q - CNT_TC;
                        end
                    end
                end
            end

            default: begin
                fsm_d = ST_IDLE;
                cnt_d = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= DAT_ZERO;
            mode_q  <= MODE_LCG;
            cnt_q   <= CNT_ZERO;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign prng_r_dat = state_q;
    assign prng_r_vld = (fsm_q == ST_RUN);
    assign prng_busy  = (fsm_q == ST_RUN);
    assign prng_err   = err_q;

endmodule

// File: tb/tb_prng_burst.sv
// Bench for prng_burst: a queue-based burst model checked every cycle, plus literal
// expectations for the known LCG/LFSR sequences, reset, abort and error cases.
module tb_prng_burst;

    localparam int W  = 25;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic [1:0]    typ = 2'd0;
    logic [W-1:0]  tdat = '0;
    logic [BW-1:0] blen = '0;
    logic          rdy = 1'b0;
    logic [W-1:0]  dat;
    logic          vld;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: current visible word, pending burst words, flags
    logic [W-1:0]  m_dat  = '0;
    logic          m_mode = 1'b0;
    logic          m_err  = 1'b0;
    logic          m_run  = 1'b0;
    logic [W-1:0]  m_q[$];

    prng_burst dut (
        .clk            (clk),
        .rst            (rst),
        .prng_t_sel     (sel),
        .prng_typ_sel   (typ),
        .prng_t_dat     (tdat),
        .prng_burst_len (blen),
        .prng_r_dat     (dat),
        .prng_r_vld     (vld),
        .prng_r_rdy     (rdy),
        .prng_busy      (busy),
        .prng_err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_next(input logic [W-1:0] s, input logic lfsr);
        longint v;
        if (lfsr) begin
            if (s[0]) return (s >> 1) ^ 25'h1200000;
            return s >> 1;
        end
        v = (longint'(s) * 64'd1664525 + 64'd12345) % 64'd33554432;
        return W'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] t, input logic [W-1:0] d, input logic [BW-1:0] l);
        sel  = 1'b1;
        typ  = t;
        tdat = d;
        blen = l;
        tick();
        sel  = 1'b0;
        typ  = 2'd0;
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] e_dat, input logic e_vld,
                           input logic e_busy, input logic e_err);
        chk({name, ".dat"},  32'(dat),  32'(e_dat));
        chk({name, ".vld"},  32'(vld),  32'(e_vld));
        chk({name, ".busy"}, 32'(busy), 32'(e_busy));
        chk({name, ".err"},  32'(err),  32'(e_err));
    endtask

    // model update
    initial begin
        logic [W-1:0] w;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_dat  = '0;
                m_mode = 1'b0;
                m_err  = 1'b0;
                m_run  = 1'b0;
                m_q.delete();
            end else if (m_run) begin
                if (sel && typ == 2'd0) begin
                    m_run = 1'b0;
                    m_q.delete();
                end else begin
                    if (sel) m_err = 1'b1;
                    if (rdy) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_run = 1'b0;
                        else m_dat = m_q[0];
                    end
                end
            end else if (sel) begin
                case (typ)
                    2'd1: if (blen != 0) begin
                        w = m_dat;
                        for (int k = 0; k < int'(blen); k++) begin
                            w = ref_next(w, m_mode);
                            m_q.push_back(w);
                        end
                        m_dat = m_q[0];
                        m_run = 1'b1;
                    end
                    2'd2: if (m_mode && tdat == 0) m_err = 1'b1;
                          else begin m_dat = tdat; m_err = 1'b0; end
                    2'd3: begin
                        m_mode = tdat[0];
                        if (tdat[0] && m_dat == 0) begin m_dat = 1; m_err = 1'b1; end
                    end
                    default: ;
                endcase
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #4;
            chk("model.dat",  32'(dat),  32'(m_dat));
            chk("model.vld",  32'(vld),  32'(m_run));
            chk("model.busy", 32'(busy), 32'(m_run));
            chk("model.err",  32'(err),  32'(m_err));
        end
    end

    initial begin
        logic [W-1:0] w2;
        repeat (2) tick();
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("post_reset", '0, 1'b0, 1'b0, 1'b0);

        // 1: LCG single word
        cmd(2'd2, 25'd100, 0);
        chk_out("t1_seed", 25'd100, 1'b0, 1'b0, 1'b0);
        rdy = 1'b1;
        cmd(2'd1, 0, 8'd1);
        chk_out("t1_word", 25'd32247117, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t1_done", 25'd32247117, 1'b0, 1'b0, 1'b0);
        rdy = 1'b0;

        // 2: LFSR burst of 3 with continuous ready
        cmd(2'd3, 25'd1, 0);
        cmd(2'd2, 25'd1, 0);
        rdy = 1'b1;
        cmd(2'd1, 0, 8'd3);
        chk_out("t2_w1", 25'h1200000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t2_w2", 25'h0900000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t2_w3", 25'h0480000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t2_done", 25'h0480000, 1'b0, 1'b0, 1'b0);
        rdy = 1'b0;

        // 3: same burst with a 4-cycle stall
        cmd(2'd2, 25'd1, 0);
        cmd(2'd1, 0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            chk_out("t3_stall", 25'h1200000, 1'b1, 1'b1, 1'b0);
            tick();
        end
        rdy = 1'b1;
        chk_out("t3_hold", 25'h1200000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t3_w2", 25'h0900000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t3_w3", 25'h0480000, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t3_done", 25'h0480000, 1'b0, 1'b0, 1'b0);
        rdy = 1'b0;

        // 4: zero seed in LFSR mode, then recovery; LFSR switch with zero state
        cmd(2'd2, 25'd0, 0);
        chk_out("t4_zero_seed", 25'h0480000, 1'b0, 1'b0, 1'b1);
        cmd(2'd2, 25'd5, 0);
        chk_out("t4_seed5", 25'd5, 1'b0, 1'b0, 1'b0);
        cmd(2'd3, 25'd0, 0);
        cmd(2'd2, 25'd0, 0);
        chk_out("t4_lcg_zero", 25'd0, 1'b0, 1'b0, 1'b0);
        cmd(2'd3, 25'd1, 0);
        chk_out("t4_mode_fix", 25'd1, 1'b0, 1'b0, 1'b1);
        cmd(2'd0, 25'd7, 0);
        chk_out("t4_idle_halt", 25'd1, 1'b0, 1'b0, 1'b1);

        // 5: abort with simultaneous ready; seed load during run
        cmd(2'd3, 25'd0, 0);
        cmd(2'd2, 25'd100, 0);
        cmd(2'd1, 0, 8'd10);
        chk_out("t5_w1", 25'd32247117, 1'b1, 1'b1, 1'b0);
        w2 = ref_next(25'd32247117, 1'b0);
        rdy = 1'b1;
        tick();
        chk_out("t5_w2", w2, 1'b1, 1'b1, 1'b0);
        rdy = 1'b0;
        cmd(2'd2, 25'd7, 0);
        chk_out("t5_seed_in_run", w2, 1'b1, 1'b1, 1'b1);
        rdy = 1'b1;
        cmd(2'd0, 0, 0);
        chk_out("t5_abort", w2, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("t5_after_abort", w2, 1'b0, 1'b0, 1'b1);
        rdy = 1'b0;

        // 6: zero-length start, then reset mid-burst
        cmd(2'd2, 25'd3, 0);
        rdy = 1'b1;
        cmd(2'd1, 0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            chk_out("t6_len0", 25'd3, 1'b0, 1'b0, 1'b0);
            tick();
        end
        rdy = 1'b0;
        cmd(2'd3, 25'd1, 0);
        cmd(2'd1, 0, 8'd5);
        chk_out("t6_run", ref_next(25'd3, 1'b1), 1'b1, 1'b1, 1'b0);
        cmd(2'd2, 25'd9, 0);
        #1 rst = 1'b1;
        #1 chk_out("t6_async_rst", '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        cmd(2'd2, 25'd100, 0);
        rdy = 1'b1;
        cmd(2'd1, 0, 8'd1);
        chk_out("t6_mode_lcg", 25'd32247117, 1'b1, 1'b1, 1'b0);
        tick();

        // maximum burst; a start on the final handshake edge is refused
        cmd(2'd2, 25'd1, 0);
        cmd(2'd1, 0, 8'd255);
        repeat (254) tick();
        chk_out("max_last_word", m_dat, 1'b1, 1'b1, 1'b0);
        cmd(2'd1, 0, 8'd5);
        chk_out("max_b2b", m_dat, 1'b0, 1'b0, 1'b1);
        tick();
        chk("max_no_restart", 32'(vld), 32'd0);
        rdy = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
